// File: rtl/st7735_pkg.sv
// Shared ST7735 definitions: opcodes, decoder state encoding and a clamp helper.
// Used by the panel sink and by the ST7735 driver.
package st7735_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_MADCTL  = 8'h36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_ARG,
    ST_RASET_ARG,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_IGNORE,
    ST_MADCTL_ARG
  } dec_state_e;

  function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/st7735_sink_if.sv
// ST7735 serial pins plus the decoded sink outputs, in one bundle.
interface st7735_sink_if;
  logic        CS;
  logic        LCD_CLK;
  logic        MOSI;
  logic        DC;
  logic        LCD_RST_N;
  logic        CMD_VALID;
  logic [7:0]  CMD_BYTE;
  logic        PIXEL_VALID;
  logic [15:0] PIXEL_DATA;
  logic [15:0] PIXEL_X;
  logic [15:0] PIXEL_Y;
  logic        FRAME_DONE;
  logic        ERR_PARTIAL;

  modport master (
    output CS, LCD_CLK, MOSI, DC, LCD_RST_N,
    input  CMD_VALID, CMD_BYTE, PIXEL_VALID, PIXEL_DATA, PIXEL_X, PIXEL_Y,
           FRAME_DONE, ERR_PARTIAL
  );

  modport slave (
    input  CS, LCD_CLK, MOSI, DC, LCD_RST_N,
    output CMD_VALID, CMD_BYTE, PIXEL_VALID, PIXEL_DATA, PIXEL_X, PIXEL_Y,
           FRAME_DONE, ERR_PARTIAL
  );
endinterface

// File: rtl/spi_sink_shifter.sv
// SPI mode-0 receive front end: synchronizers, LCD_CLK rise detect, byte assembly.
// Strobes are combinational in the detection cycle so the decoder registers them one cycle later.
module spi_sink_shifter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_n_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       dc_i,
  input  logic       lcd_rst_n_i,
  output logic [7:0] byte_o,
  output logic       dc_o,
  output logic       byte_stb_o,
  output logic       abort_stb_o,
  output logic       cs_idle_o,
  output logic       panel_rst_o
);

  logic [1:0] cs_q, sclk_q, mosi_q, dc_q, rstn_q;
  logic       sclk_prev_q;
  logic [2:0] cnt_q;
  logic [6:0] sh_q;
  logic       rise;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_q        <= 2'b11;
      rstn_q      <= 2'b11;
      sclk_q      <= 2'b00;
      mosi_q      <= 2'b00;
      dc_q        <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_q        <= {cs_q[0], cs_n_i};
      rstn_q      <= {rstn_q[0], lcd_rst_n_i};
      sclk_q      <= {sclk_q[0], sclk_i};
      mosi_q      <= {mosi_q[0], mosi_i};
      dc_q        <= {dc_q[0], dc_i};
      sclk_prev_q <= sclk_q[1];
    end
  end

  assign rise        = sclk_q[1] & ~sclk_prev_q;
  assign panel_rst_o = ~rstn_q[1];
  assign cs_idle_o   = cs_q[1];

  // The panel reset pin clears the bit counter but never its own synchronizer.
  always_ff @(posedge clk_i) begin
    if (rst_i || panel_rst_o || cs_q[1]) begin
      cnt_q <= 3'd0;
    end else if (rise) begin
      cnt_q <= cnt_q + 3'd1;
      sh_q  <= {sh_q[5:0], mosi_q[1]};
    end
  end

  assign byte_o      = {sh_q, mosi_q[1]};
  assign dc_o        = dc_q[1];
  assign byte_stb_o  = rise & ~cs_q[1] & ~panel_rst_o & (cnt_q == 3'd7);
  assign abort_stb_o = cs_q[1] & (cnt_q != 3'd0);

endmodule

// File: rtl/st7735_sink.sv
// ST7735 panel model: decodes CASET/RASET/RAMWR/SWRESET into a pixel stream with coordinates.
// Optional MADCTL mirroring/swap is built when ST7735_SINK_MADCTL_EN is defined.
module st7735_sink
  import st7735_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input logic         SYSTEM_CLK,
  input logic         RESET,
  st7735_sink_if.slave bus
);

  localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
  localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);

  logic [7:0] rx_byte;
  logic       rx_dc, byte_stb, abort_stb, cs_idle, panel_rst, core_rst;

  spi_sink_shifter u_shifter (
    .clk_i       (SYSTEM_CLK),
    .rst_i       (RESET),
    .cs_n_i      (bus.CS),
    .sclk_i      (bus.LCD_CLK),
    .mosi_i      (bus.MOSI),
    .dc_i        (bus.DC),
    .lcd_rst_n_i (bus.LCD_RST_N),
    .byte_o      (rx_byte),
    .dc_o        (rx_dc),
    .byte_stb_o  (byte_stb),
    .abort_stb_o (abort_stb),
    .cs_idle_o   (cs_idle),
    .panel_rst_o (panel_rst)
  );

  assign core_rst = RESET | panel_rst;

  dec_state_e  state_q;
  logic [1:0]  arg_cnt_q;
  logic [7:0]  arg_hi_q, pix_hi_q;
  logic [15:0] arg_s_q, xs_q, xe_q, ys_q, ye_q, cx_q, cy_q;
  logic        cmd_vld_q, pix_vld_q, frame_q, err_q;
  logic [7:0]  cmd_byte_q;
  logic [15:0] pix_data_q, pix_x_q, pix_y_q;
  logic [15:0] arg_val_d, arg_end_d, out_x_d, out_y_d;
  logic        frame_end_d;
`ifdef ST7735_SINK_MADCTL_EN
  logic [2:0]  madctl_q;
  logic [15:0] mir_x, mir_y;
`endif

  always_comb begin
    arg_val_d   = clamp16({arg_hi_q, rx_byte}, (state_q == ST_CASET_ARG) ? X_MAX : Y_MAX);
    arg_end_d   = (arg_s_q > arg_val_d) ? arg_s_q : arg_val_d;
    frame_end_d = (cx_q >= xe_q) && (cy_q >= ye_q);
`ifdef ST7735_SINK_MADCTL_EN
    mir_x   = madctl_q[1] ? (X_MAX - cx_q) : cx_q;
    mir_y   = madctl_q[2] ? (Y_MAX - cy_q) : cy_q;
    out_x_d = madctl_q[0] ? mir_y : mir_x;
    out_y_d = madctl_q[0] ? mir_x : mir_y;
`else
    out_x_d = cx_q;
    out_y_d = cy_q;
`endif
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (core_rst) begin
      state_q    <= ST_IDLE;
      arg_cnt_q  <= 2'd0;
      arg_hi_q   <= 8'h00;
      arg_s_q    <= 16'h0000;
      pix_hi_q   <= 8'h00;
      xs_q       <= 16'h0000;
      xe_q       <= X_MAX;
      ys_q       <= 16'h0000;
      ye_q       <= Y_MAX;
      cx_q       <= 16'h0000;
      cy_q       <= 16'h0000;
      cmd_vld_q  <= 1'b0;
      cmd_byte_q <= 8'h00;
      pix_vld_q  <= 1'b0;
      pix_data_q <= 16'h0000;
      pix_x_q    <= 16'h0000;
      pix_y_q    <= 16'h0000;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef ST7735_SINK_MADCTL_EN
      madctl_q   <= 3'b000;
`endif
    end else begin
      cmd_vld_q <= 1'b0;
      pix_vld_q <= 1'b0;
      frame_q   <= 1'b0;
      err_q     <= abort_stb;
      // A deselect drops any half-received pixel; the window and cursor survive.
      if (cs_idle && state_q == ST_RAMWR_LO) state_q <= ST_RAMWR_HI;
      if (byte_stb) begin
        if (!rx_dc) begin
          cmd_vld_q  <= 1'b1;
          cmd_byte_q <= rx_byte;
          arg_cnt_q  <= 2'd0;
          case (rx_byte)
            OP_SWRESET: begin
              xs_q    <= 16'h0000;
              xe_q    <= X_MAX;
              ys_q    <= 16'h0000;
              ye_q    <= Y_MAX;
              state_q <= ST_IDLE;
            end
            OP_CASET: state_q <= ST_CASET_ARG;
            OP_RASET: state_q <= ST_RASET_ARG;
            OP_RAMWR: begin
              cx_q    <= xs_q;
              cy_q    <= ys_q;
              state_q <= ST_RAMWR_HI;
            end
`ifdef ST7735_SINK_MADCTL_EN
            OP_MADCTL: state_q <= ST_MADCTL_ARG;
`endif
            default: state_q <= ST_IGNORE;
          endcase
        end else begin
          case (state_q)
            ST_CASET_ARG, ST_RASET_ARG: begin
              arg_cnt_q <= arg_cnt_q + 2'd1;
              if (!arg_cnt_q[0]) begin
                arg_hi_q <= rx_byte;
              end else if (!arg_cnt_q[1]) begin
                arg_s_q <= arg_val_d;
              end else begin
                if (state_q == ST_CASET_ARG) begin
                  xs_q <= arg_s_q;
                  xe_q <= arg_end_d;
                end else begin
                  ys_q <= arg_s_q;
                  ye_q <= arg_end_d;
                end
                state_q <= ST_IDLE;
              end
            end
            ST_RAMWR_HI: begin
              pix_hi_q <= rx_byte;
              state_q  <= ST_RAMWR_LO;
            end
            ST_RAMWR_LO: begin
              pix_vld_q  <= 1'b1;
              pix_data_q <= {pix_hi_q, rx_byte};
              pix_x_q    <= out_x_d;
              pix_y_q    <= out_y_d;
              frame_q    <= frame_end_d;
              state_q    <= ST_RAMWR_HI;
              if (cx_q >= xe_q) begin
                cx_q <= xs_q;
                cy_q <= (cy_q >= ye_q) ? ys_q : cy_q + 16'd1;
              end else begin
                cx_q <= cx_q + 16'd1;
              end
            end
`ifdef ST7735_SINK_MADCTL_EN
            ST_MADCTL_ARG: begin
              madctl_q <= rx_byte[7:5];
              state_q  <= ST_IDLE;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.CMD_VALID   = cmd_vld_q;
  assign bus.CMD_BYTE    = cmd_byte_q;
  assign bus.PIXEL_VALID = pix_vld_q;
  assign bus.PIXEL_DATA  = pix_data_q;
  assign bus.PIXEL_X     = pix_x_q;
  assign bus.PIXEL_Y     = pix_y_q;
  assign bus.FRAME_DONE  = frame_q;
  assign bus.ERR_PARTIAL = err_q;

endmodule
